// File: rtl/ascon_aead_sequencer_pkg.sv
// Shared types and helpers for the Ascon AEAD control sequencer.
package ascon_pack;

   // Index of the final round of every permutation (p^a and p^b both end here).
   localparam int MAX_ROUND_IDX = 11;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      INIT    = 4'd1,
      WAIT_AD = 4'd2,
      AD_PERM = 4'd3,
      WAIT_PT = 4'd4,
      PT_PERM = 4'd5,
      FINAL   = 4'd6,
      TAG     = 4'd7,
      DONE    = 4'd8
   } seq_state_t;

   // A permutation of n rounds starts at index 12-n so that it always ends on index 11.
   function automatic int unsigned round_start(input int unsigned n);
      return 32'd12 - n;
   endfunction

endpackage

// File: rtl/ascon_aead_sequencer_if.sv
// Block handshake between the upstream data source and the sequencer.
interface ascon_aead_sequencer_if;
   logic blk_valid_i;
   logic blk_last_i;
   logic blk_ready_o;

   modport master (output blk_valid_i, output blk_last_i, input blk_ready_o);
   modport slave  (input blk_valid_i, input blk_last_i, output blk_ready_o);
endinterface

// File: rtl/ascon_aead_sequencer_round_counter.sv
// Round index counter: loads a permutation start index, steps once per
// executed round and saturates at the terminal index.
module ascon_round_counter
   import ascon_pack::*;
#(
   parameter int ROUND_W = 4
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic               en_i,
   input  logic [ROUND_W-1:0] load_val_i,
   output logic [ROUND_W-1:0] idx_o,
   output logic               last_o
);

   localparam logic [ROUND_W-1:0] TERM = ROUND_W'(MAX_ROUND_IDX);

   logic [ROUND_W-1:0] cnt_q, cnt_d;
   logic [ROUND_W-1:0] cur;

   // A load coinciding with a round makes the loaded value the index of that round.
   assign cur    = load_i ? load_val_i : cnt_q;
   assign idx_o  = en_i ? cur : cnt_q;
   assign last_o = (cur == TERM);

   // Next index: step on a round (no wrap past the terminal), else take a pending load.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = last_o ? cur : cur + 1'b1;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end
   end

   // Index register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ascon_aead_sequencer.sv
// Control sequencer for one Ascon AEAD encryption pass:
// init, AD absorption, PT encryption, finalisation and tag release.
//
// state   | meaning
// IDLE    | after reset, waiting for start_i
// INIT    | p^a over IV||K||N, key/domain XOR on last round
// WAIT_AD | waiting for an AD block; handshake cycle is p^b round 1
// AD_PERM | remaining p^b rounds of an AD block
// WAIT_PT | waiting for a PT block; handshake emits ciphertext
// PT_PERM | remaining p^b rounds of a non-final PT block
// FINAL   | remaining p^a rounds after the last PT block
// TAG     | one-cycle tag release
// DONE    | pass complete, end_o held until next start_i
module ascon_aead_sequencer
   import ascon_pack::*;
#(
   parameter int PA_ROUNDS = 12,
   parameter int PB_ROUNDS = 6,
   parameter int ROUND_W   = 4
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                start_i,
   input  logic                ad_present_i,
   ascon_aead_sequencer_if.slave blk,
   output logic [ROUND_W-1:0]  round_o,
   output logic                perm_en_o,
   output logic                input_mode_o,
   output logic                xor_data_o,
   output logic                xor_key_begin_o,
   output logic                xor_key_end_o,
   output logic                xor_lsb_o,
   output logic                cipher_valid_o,
   output logic                tag_valid_o,
   output logic                busy_o,
   output logic                end_o
);

   localparam logic [3:0] S_IDLE    = IDLE;
   localparam logic [3:0] S_INIT    = INIT;
   localparam logic [3:0] S_WAIT_AD = WAIT_AD;
   localparam logic [3:0] S_AD_PERM = AD_PERM;
   localparam logic [3:0] S_WAIT_PT = WAIT_PT;
   localparam logic [3:0] S_PT_PERM = PT_PERM;
   localparam logic [3:0] S_FINAL   = FINAL;
   localparam logic [3:0] S_TAG     = TAG;
   localparam logic [3:0] S_DONE    = DONE;

   localparam logic [ROUND_W-1:0] PA_START = ROUND_W'(round_start(PA_ROUNDS));
   localparam logic [ROUND_W-1:0] PB_START = ROUND_W'(round_start(PB_ROUNDS));

   logic [3:0]         state_q, state_d;
   logic               ad_q, ad_d;
   logic               blk_last_q, blk_last_d;
   logic               in_wait, wait_hs, idle_like;
   logic               cnt_load, cnt_last;
   logic [ROUND_W-1:0] cnt_val;

   assign in_wait   = (state_q == S_WAIT_AD) || (state_q == S_WAIT_PT);
   assign wait_hs   = in_wait && blk.blk_valid_i;
   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

   assign blk.blk_ready_o = in_wait;
   assign busy_o          = !idle_like;
   assign end_o           = (state_q == S_TAG) || (state_q == S_DONE);
   assign tag_valid_o     = (state_q == S_TAG);

   assign perm_en_o = wait_hs || (state_q == S_INIT) || (state_q == S_AD_PERM) ||
                      (state_q == S_PT_PERM) || (state_q == S_FINAL);

   // The counter is primed on start and reloaded in the handshake cycle itself;
   // only the last PT block starts a p^a, every other block a p^b.
   assign cnt_load = wait_hs || (idle_like && start_i);
   assign cnt_val  = ((state_q == S_WAIT_AD) || ((state_q == S_WAIT_PT) && !blk.blk_last_i))
                     ? PB_START : PA_START;

   ascon_round_counter #(.ROUND_W(ROUND_W)) u_round_counter (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .load_i     (cnt_load),
      .en_i       (perm_en_o),
      .load_val_i (cnt_val),
      .idx_o      (round_o),
      .last_o     (cnt_last)
   );

   // Next-state and per-round datapath qualifiers.
   always_comb begin
      state_d         = state_q;
      ad_d            = ad_q;
      blk_last_d      = blk_last_q;
      input_mode_o    = 1'b0;
      xor_data_o      = 1'b0;
      xor_key_begin_o = 1'b0;
      xor_key_end_o   = 1'b0;
      xor_lsb_o       = 1'b0;
      cipher_valid_o  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_INIT;
               ad_d    = ad_present_i;
            end
         end
         S_INIT: begin
            input_mode_o = (round_o == PA_START);
            if (cnt_last) begin
               xor_key_end_o = 1'b1;
               xor_lsb_o     = !ad_q;
               state_d       = ad_q ? S_WAIT_AD : S_WAIT_PT;
            end
         end
         S_WAIT_AD: begin
            if (blk.blk_valid_i) begin
               xor_data_o = 1'b1;
               blk_last_d = blk.blk_last_i;
               if (!cnt_last) begin
                  state_d = S_AD_PERM;
               end else if (blk.blk_last_i) begin
                  xor_lsb_o = 1'b1;
                  state_d   = S_WAIT_PT;
               end
            end
         end
         S_AD_PERM: begin
            if (cnt_last) begin
               xor_lsb_o = blk_last_q;
               state_d   = blk_last_q ? S_WAIT_PT : S_WAIT_AD;
            end
         end
         S_WAIT_PT: begin
            if (blk.blk_valid_i) begin
               xor_data_o     = 1'b1;
               cipher_valid_o = 1'b1;
               if (blk.blk_last_i) begin
                  xor_key_begin_o = 1'b1;
                  if (cnt_last) begin
                     xor_key_end_o = 1'b1;
                     state_d       = S_TAG;
                  end else begin
                     state_d = S_FINAL;
                  end
               end else if (!cnt_last) begin
                  state_d = S_PT_PERM;
               end
            end
         end
         S_PT_PERM: begin
            if (cnt_last) begin
               state_d = S_WAIT_PT;
            end
         end
         S_FINAL: begin
            if (cnt_last) begin
               xor_key_end_o = 1'b1;
               state_d       = S_TAG;
            end
         end
         S_TAG: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, AD-present flag and last-block flag registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         ad_q       <= 1'b0;
         blk_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ad_q       <= ad_d;
         blk_last_q <= blk_last_d;
      end
   end

endmodule
